// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Arbitrates two 16-bit sample channels onto a byte-wide UART transmitter.
//   Each accepted sample is sent as a 3-byte frame:
//     header (HDR0 or HDR1), sample[15:8], sample[7:0].
//   Every byte is handed over as a one-cycle tx_start pulse. The scheduler then
//   waits for the transmitter's busy flag to rise and fall before it moves on.
//   If busy never rises, the frame is abandoned and a sticky error flag is set.
//
// Parameters
//   HDR0, HDR1   header bytes for channel 0 / channel 1 frames
//   ACK_TIMEOUT  cycles, counted from the tx_start cycle, allowed for tx_busy to rise
//   FRAMES_INIT  reset value of frames_sent (normally 0)
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   reqN_valid / reqN_data    channel N holds a 16-bit sample
//   reqN_ready                one-cycle accept strobe for channel N
//   tx_start / tx_data        byte handover to the transmitter (tx_data is 0 otherwise)
//   tx_busy                   transmitter busy flag
//   frames_sent               completed-frame counter, wraps to 0
//   timeout_err               sticky; set when tx_busy fails to rise
//   sched_busy                high whenever a frame is in progress
module uart_tx_scheduler #(
  parameter logic [7:0]  HDR0        = 8'hA0,
  parameter logic [7:0]  HDR1        = 8'hA1,
  parameter int          ACK_TIMEOUT = 4,
  parameter logic [15:0] FRAMES_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [15:0] frames_sent,
  output logic        timeout_err,
  output logic        sched_busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_e;

  localparam int CntW = $clog2(ACK_TIMEOUT + 1) + 1;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     sample_q, sample_d;
  logic            chan_q, chan_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     frames_q, frames_d;
  logic            err_q, err_d;
  logic            grant_ch;

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the values from before the edge, whatever the order of statements.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      sample_q <= 16'h0000;
      chan_q   <= 1'b0;
      last_q   <= 1'b1;          // channel 0 wins the first contention
      cnt_q    <= '0;
      frames_q <= FRAMES_INIT;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sample_q <= sample_d;
      chan_q   <= chan_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      frames_q <= frames_d;
      err_q    <= err_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sample_d   = sample_q;
    chan_d     = chan_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    frames_d   = frames_q;
    err_d      = err_q;
    grant_ch   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    tx_start   = 1'b0;
    tx_data    = 8'h00;

    case (state_q)
      IDLE: begin
        if (!tx_busy && (req0_valid || req1_valid)) begin
          // Under contention, alternate away from the previous winner.
          // Otherwise grant the only requester.
          grant_ch   = (req0_valid && req1_valid) ? ~last_q : ~req0_valid;
          req0_ready = ~grant_ch;
          req1_ready = grant_ch;
          sample_d   = grant_ch ? req1_data : req0_data;
          chan_d     = grant_ch;
          last_d     = grant_ch;
          idx_d      = 2'd0;
          state_d    = START;
        end
      end
      START: begin
        tx_start = 1'b1;
        case (idx_q)
          2'd0:    tx_data = chan_q ? HDR1 : HDR0;
          2'd1:    tx_data = sample_q[15:8];
          default: tx_data = sample_q[7:0];
        endcase
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        // The START cycle is the first of the ACK_TIMEOUT busy-low cycles.
        // The counter starts at 0 in the first WAIT_HI cycle, so the window
        // closes when it reaches ACK_TIMEOUT-2.
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (int'(cnt_q) + 2 >= ACK_TIMEOUT) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == 2'd2) begin
            frames_d = frames_q + 16'd1;
            state_d  = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // While reset is asserted, no sample is accepted and no byte is launched.
    if (rst) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      tx_start   = 1'b0;
      tx_data    = 8'h00;
    end
  end

  assign frames_sent = frames_q;
  assign timeout_err = err_q;
  assign sched_busy  = (state_q != IDLE);

endmodule
